// File: rtl/leaf_input_buffer_pkg.sv
// Shared flit-format and router FSM definitions for the leaf and hub router blocks.
package leaf_input_buffer_pkg;

  localparam int unsigned TYPE_W   = 2;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned PORT_W   = 4;
  localparam int unsigned SRC_LSB  = 0;
  localparam int unsigned DEST_LSB = SRC_LSB + ADDR_W;
  localparam int unsigned HDR_W    = 2 * ADDR_W;

  // Flit type lives in the two MSBs of every flit.
  typedef enum logic [TYPE_W-1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ROUTE = 2'b01,
    ST_FWD   = 2'b10
  } rtr_state_e;

  // Address fields in the low byte of HEAD and SINGLE flits: dest above src.
  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] src;
  } hdr_addr_t;

  function automatic logic is_header(input flit_type_e t);
    return (t == FT_HEAD) || (t == FT_SINGLE);
  endfunction

  function automatic logic is_last(input flit_type_e t);
    return (t == FT_TAIL) || (t == FT_SINGLE);
  endfunction

  function automatic hdr_addr_t hdr_fields(input logic [HDR_W-1:0] low_bits);
    return hdr_addr_t'(low_bits);
  endfunction

endpackage

// File: rtl/leaf_input_buffer_fifo.sv
// Flit FIFO with wrap-around pointers; illegal push/pop requests are ignored.
module flit_fifo #(
  parameter int unsigned FLIT_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_flit,
  input  logic              pop,
  output logic [FLIT_W-1:0] head_flit,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [FLIT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_flit = mem_q[rd_ptr_q];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_flit;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_count_bounded: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/leaf_input_buffer.sv
// Leaf router input port: buffers link flits, latches header addresses for the
// route logic, registers the returned port and forwards the packet to the crossbar.
module leaf_input_buffer
  import leaf_input_buffer_pkg::*;
#(
  parameter int unsigned FLIT_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dest_addr,
  input  logic [PORT_W-1:0] route_port,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PORT_W-1:0] out_port
);

  rtr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [PORT_W-1:0] port_q, port_d;
  logic [FLIT_W-1:0] head_flit;
  logic              fifo_full, fifo_empty;
  logic              fifo_push, fifo_pop;
  flit_type_e        head_type;
  hdr_addr_t         head_hdr;

  // Acceptance depends only on occupancy, never on a same-cycle pop.
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;

  flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_flit (in_flit),
    .pop       (fifo_pop),
    .head_flit (head_flit),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_type = flit_type_e'(head_flit[FLIT_W-1 -: TYPE_W]);
  assign head_hdr  = hdr_fields(head_flit[HDR_W-1:0]);

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dest_d    = dest_q;
    port_d    = port_q;
    fifo_pop  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      // Headers start a packet; stray BODY/TAIL flits are discarded here.
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (is_header(head_type)) begin
            src_d   = head_hdr.src;
            dest_d  = head_hdr.dest;
            state_d = ST_ROUTE;
          end else begin
            fifo_pop = 1'b1;
          end
        end
      end
      ST_ROUTE: begin
        port_d  = route_port;
        state_d = ST_FWD;
      end
      ST_FWD: begin
        out_valid = !fifo_empty;
        if (out_valid && out_ready) begin
          fifo_pop = 1'b1;
          if (is_last(head_type)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dest_q  <= '0;
      port_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dest_q  <= dest_d;
      port_q  <= port_d;
    end
  end

  assign src_addr  = src_q;
  assign dest_addr = dest_q;
  assign out_port  = port_q;
  assign out_flit  = head_flit;

endmodule

// File: tb/tb_leaf_input_buffer.sv
// Self-checking bench for leaf_input_buffer: directed scenarios plus a randomized
// run scored against a packet-level reference model.
module tb_leaf_input_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  src_addr, dest_addr, route_port, out_port;
  logic [15:0] out_flit;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic        rp_auto = 1'b0;
  logic [3:0]  rp_man  = '0;
  int          tests_run = 0;
  int          tests_failed = 0;

  typedef struct packed {
    logic [15:0] flit;
    logic [3:0]  port;
    logic [3:0]  src;
    logic [3:0]  dest;
  } exp_t;

  exp_t        exp_q[$];
  bit          in_pkt;
  logic [3:0]  pkt_port, pkt_src, pkt_dest;

  // Route logic stand-in: either a fixed port or a function of the latched dest.
  assign route_port = rp_auto ? (dest_addr ^ 4'hA) : rp_man;

  always #5 clk = ~clk;

  leaf_input_buffer #(.FLIT_W(16), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src_addr   (src_addr),
    .dest_addr  (dest_addr),
    .route_port (route_port),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_port   (out_port)
  );

  // Packet-level model: which accepted flits reach the crossbar, and with what header.
  task automatic model_push(input logic [15:0] f);
    logic [1:0] t;
    bit hdr, last;
    t    = f[15:14];
    hdr  = (t == 2'b01) || (t == 2'b11);
    last = (t == 2'b10) || (t == 2'b11);
    if (!in_pkt && !hdr) return;
    if (!in_pkt) begin
      pkt_dest = f[7:4];
      pkt_src  = f[3:0];
      pkt_port = f[7:4] ^ 4'hA;
    end
    exp_q.push_back('{flit: f, port: pkt_port, src: pkt_src, dest: pkt_dest});
    in_pkt = !last;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rp_auto = 1'b0; rp_man = 4'h0;
    repeat (2) @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (out_port !== 4'h0) begin tests_failed++; $display("FAIL reset_out_port: got %h want 0", out_port); end
    tests_run++; if (src_addr !== 4'h0) begin tests_failed++; $display("FAIL reset_src: got %h want 0", src_addr); end
    tests_run++; if (dest_addr !== 4'h0) begin tests_failed++; $display("FAIL reset_dest: got %h want 0", dest_addr); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    rp_auto = 1'b0; rp_man = 4'b0001; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_flit = 16'hC035;
    @(negedge clk); in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_valid_c1: got %b want 0", out_valid); end
    @(negedge clk);
    tests_run++; if (dest_addr !== 4'h3 || src_addr !== 4'h5) begin tests_failed++; $display("FAIL single_addr: got dest=%h src=%h want dest=3 src=5", dest_addr, src_addr); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_valid_c2: got %b want 0", out_valid); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1 || out_port !== 4'b0001 || out_flit !== 16'hC035) begin tests_failed++; $display("FAIL single_out: got valid=%b port=%h flit=%h want 1 1 c035", out_valid, out_port, out_flit); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL single_popped: got valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_full_packet;
    logic [15:0] pkt [4];
    logic [15:0] got[$];
    logic [3:0]  gport[$];
    pkt = '{16'h4021, 16'h0ABC, 16'h1234, 16'h8DEF};
    rp_auto = 1'b0; rp_man = 4'h6; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL fill_in_ready_%0d: got %b want 1", i, in_ready); end
      in_valid = 1'b1; in_flit = pkt[i];
    end
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    in_flit = 16'hC0EE;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (out_valid) begin got.push_back(out_flit); gport.push_back(out_port); end
    end
    tests_run++;
    if (got.size() != 4) begin
      tests_failed++; $display("FAIL full_count: got %0d flits want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got[i] !== pkt[i] || gport[i] !== 4'h6) begin tests_failed++; $display("FAIL full_order_%0d: got %h port %h want %h port 6", i, got[i], gport[i], pkt[i]); end
      end
    end
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_idle: got valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_orphan;
    bit saw_valid;
    rp_auto = 1'b0; rp_man = 4'h3; out_ready = 1'b1; saw_valid = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_flit = 16'h0777;
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    tests_run++; if (saw_valid) begin tests_failed++; $display("FAIL orphan_valid: got out_valid=1 want 0"); end
    // An empty FIFO gives the exact minimum header latency.
    @(negedge clk); in_valid = 1'b1; in_flit = 16'hC0A1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL orphan_early_valid: got %b want 0", out_valid); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1 || out_flit !== 16'hC0A1 || out_port !== 4'h3 || dest_addr !== 4'hA || src_addr !== 4'h1) begin
      tests_failed++; $display("FAIL orphan_next: got valid=%b flit=%h port=%h dest=%h src=%h want 1 c0a1 3 a 1", out_valid, out_flit, out_port, dest_addr, src_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_packet;
    bit found;
    rp_auto = 1'b0; rp_man = 4'h7; out_ready = 1'b0; found = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_flit = 16'h4056;
    @(negedge clk); in_flit = 16'h0111;
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (out_valid !== 1'b1 || out_port !== 4'h7 || dest_addr !== 4'h5 || src_addr !== 4'h6) begin
      tests_failed++; $display("FAIL midrst_pre: got valid=%b port=%h dest=%h src=%h want 1 7 5 6", out_valid, out_port, dest_addr, src_addr);
    end
    rst = 1'b1;
    #1;
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_now: got valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    tests_run++; if (out_port !== 4'h0 || dest_addr !== 4'h0 || src_addr !== 4'h0) begin tests_failed++; $display("FAIL midrst_regs: got port=%h dest=%h src=%h want 0 0 0", out_port, dest_addr, src_addr); end
    @(negedge clk); rst = 1'b0; rp_man = 4'h9; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_flit = 16'hC0B2;
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        found = 1'b1;
        tests_run++;
        if (out_flit !== 16'hC0B2 || out_port !== 4'h9 || dest_addr !== 4'hB || src_addr !== 4'h2) begin
          tests_failed++; $display("FAIL midrst_after: got flit=%h port=%h dest=%h src=%h want c0b2 9 b 2", out_flit, out_port, dest_addr, src_addr);
        end
      end
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL midrst_timeout: got no out_valid want one"); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [15:0] flits[$];
    logic [15:0] want [5];
    logic [3:0]  wport [5];
    logic [15:0] got[$];
    logic [3:0]  gport[$];
    int tail_at, valid_at;
    flits = '{16'h4012, 16'h8AAA, 16'h4034, 16'h0BBB, 16'h8CCC};
    want  = '{16'h4012, 16'h8AAA, 16'h4034, 16'h0BBB, 16'h8CCC};
    wport = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
    rp_auto = 1'b0; rp_man = 4'h0; out_ready = 1'b1; tail_at = -1; valid_at = -1;
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      @(negedge clk);
      in_valid = (flits.size() != 0);
      if (in_valid) in_flit = flits[0];
      #1;
      if (out_valid && tail_at >= 0 && valid_at < 0) valid_at = c;
      if (out_valid) begin
        got.push_back(out_flit); gport.push_back(out_port);
        if (out_flit == 16'h8AAA) begin tail_at = c; rp_man = 4'h1; end
      end
      if (in_valid && in_ready) void'(flits.pop_front());
    end
    in_valid = 1'b0;
    tests_run++;
    if (got.size() != 5) begin
      tests_failed++; $display("FAIL b2b_count: got %0d flits want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (got[i] !== want[i] || gport[i] !== wport[i]) begin tests_failed++; $display("FAIL b2b_flit_%0d: got %h port %h want %h port %h", i, got[i], gport[i], want[i], wport[i]); end
      end
    end
    tests_run++; if (valid_at - tail_at - 1 != 2) begin tests_failed++; $display("FAIL b2b_dead: got %0d dead cycles want 2", valid_at - tail_at - 1); end
    @(negedge clk);
  endtask

  task automatic test_random;
    exp_t e;
    logic [1:0] t;
    @(negedge clk); rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); rst = 1'b0; rp_auto = 1'b1;
    exp_q.delete(); in_pkt = 1'b0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      if (c < 780) begin
        in_valid  = ($urandom_range(0, 2) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        t = 2'($urandom_range(0, 3));
        in_flit = {t, 14'($urandom)};
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL random_extra: got flit %h want none", out_flit);
        end else begin
          e = exp_q.pop_front();
          if (out_flit !== e.flit || out_port !== e.port || src_addr !== e.src || dest_addr !== e.dest) begin
            tests_failed++;
            $display("FAIL random_pop: got flit=%h port=%h src=%h dest=%h want flit=%h port=%h src=%h dest=%h",
                     out_flit, out_port, src_addr, dest_addr, e.flit, e.port, e.src, e.dest);
          end
        end
      end
      if (in_valid && in_ready) model_push(in_flit);
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL random_drain: got %0d flits left want 0", exp_q.size()); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_full_packet();
    test_orphan();
    test_reset_mid_packet();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
